// File: rtl/time_uart_tx.sv
// Clock-time UART transmitter: snapshots Hour/Min/Sec on request and sends
// the 10-byte ASCII frame "HH:MM:SS\r\n" as 8N1, LSB first.
module time_uart_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Sec,
  input  logic [6:0] Min,
  input  logic [6:0] Hour,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST_BYTE    = 9;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic [6:0]       hour_q;
  logic [6:0]       min_q;
  logic [6:0]       sec_q;
  logic [7:0]       cur_byte_c;
  logic             bit_end_c;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] tens_char(input logic [6:0] v);
    return 8'h30 + 8'(v / 7'd10);
  endfunction

  function automatic logic [7:0] units_char(input logic [6:0] v);
    return 8'h30 + 8'(v % 7'd10);
  endfunction

  assign bit_end_c = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Character for the current byte slot, always taken from the snapshot.
  always_comb begin
    cur_byte_c = 8'h0A;
    case (byte_idx)
      4'd0:    cur_byte_c = tens_char(hour_q);
      4'd1:    cur_byte_c = units_char(hour_q);
      4'd2:    cur_byte_c = 8'h3A;
      4'd3:    cur_byte_c = tens_char(min_q);
      4'd4:    cur_byte_c = units_char(min_q);
      4'd5:    cur_byte_c = 8'h3A;
      4'd6:    cur_byte_c = tens_char(sec_q);
      4'd7:    cur_byte_c = units_char(sec_q);
      4'd8:    cur_byte_c = 8'h0D;
      default: cur_byte_c = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (send) begin
            hour_q   <= sat99(Hour);
            min_q    <= sat99(Min);
            sec_q    <= sat99(Sec);
            byte_idx <= '0;
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= cur_byte_c[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte_c[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (byte_idx == 4'(LAST_BYTE)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
